uctl_sync_filter: RTL

Multi-channel, parametrised clock-domain input conditioner for the USB controller. Each of WIDTH asynchronous single-bit inputs passes through a configurable-depth flop synchroniser, an optional per-channel glitch filter (debounce counter) and an edge detector. It generalises the plain two-flop synchroniser. It sits at the controller boundary for PHY status lines (VBUS valid, line state, ID, suspend/wakeup) that need a stable, deglitched level plus single-cycle change strobes.

---
 rtl/uctl_sync_pkg.sv | 18 +
 rtl/uctl_sync_filter_ch.sv | 88 ++++++++
 rtl/uctl_sync_filter.sv | 47 ++++
 3 files changed

// File: rtl/uctl_sync_pkg.sv
// Shared constants and helpers for the uctl input-conditioning blocks.
// Holds the minimum synchroniser depth and the default PHY-status filter length.
package uctl_sync_pkg;

    localparam int UCTL_SYNC_MIN_STAGES  = 2;
    localparam int UCTL_SYNC_DEF_FILT_CNT = 3;

    // Bits needed to hold 0..filt_cnt; never less than one so unused counters stay legal.
    function automatic int uctl_sync_cnt_width(input int filt_cnt);
        int w;
        w = 1;
        while ((1 << w) < (filt_cnt + 1)) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/uctl_sync_filter_ch.sv
// One conditioning channel: flop synchroniser, optional debounce counter and
// edge detector producing single-cycle rise/fall strobes.
module uctl_sync_filter_ch
    import uctl_sync_pkg::*;
#(
    parameter int   STAGES   = 2,
    parameter int   FILT_CNT = UCTL_SYNC_DEF_FILT_CNT,
    parameter logic RST_BIT  = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic dataIn,
    output logic dataOut,
    output logic riseOut,
    output logic fallOut
);

    localparam int CW = uctl_sync_cnt_width(FILT_CNT);

    logic [STAGES-1:0] sync_reg;
    logic              sync_out;
    logic              data_out_d_reg;

    generate
        if (STAGES < UCTL_SYNC_MIN_STAGES) begin : g_bad_stages
            $error("uctl_sync_filter_ch: STAGES must be at least 2");
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_reg <= {STAGES{RST_BIT}};
        end else begin
            sync_reg <= {sync_reg[STAGES-2:0], dataIn};
        end
    end

    assign sync_out = sync_reg[STAGES-1];

    generate
        if (FILT_CNT == 0) begin : g_nofilt
            assign dataOut = sync_out;
        end else begin : g_filt
            logic [CW-1:0] cnt_reg;
            logic [CW-1:0] cnt_next;
            logic          level_reg;
            logic          level_next;

            // Any sample matching the held level clears the count, so only an
            // unbroken run of FILT_CNT differing samples moves the output.
            always_comb begin
                cnt_next   = '0;
                level_next = level_reg;
                if (sync_out != level_reg) begin
                    if (cnt_reg == CW'(FILT_CNT - 1)) begin
                        level_next = sync_out;
                    end else begin
                        cnt_next = cnt_reg + CW'(1);
                    end
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    cnt_reg   <= '0;
                    level_reg <= RST_BIT;
                end else begin
                    cnt_reg   <= cnt_next;
                    level_reg <= level_next;
                end
            end

            assign dataOut = level_reg;
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out_d_reg <= RST_BIT;
        end else begin
            data_out_d_reg <= dataOut;
        end
    end

    assign riseOut = dataOut & ~data_out_d_reg;
    assign fallOut = ~dataOut & data_out_d_reg;

endmodule

// File: rtl/uctl_sync_filter.sv
// WIDTH-channel input conditioner for PHY status lines; either a straight
// pass-through (BYPASS) or one independent uctl_sync_filter_ch per bit.
module uctl_sync_filter
    import uctl_sync_pkg::*;
#(
    parameter int               WIDTH    = 4,
    parameter int               STAGES   = 2,
    parameter int               FILT_CNT = UCTL_SYNC_DEF_FILT_CNT,
    parameter logic [WIDTH-1:0] RST_VAL  = '0,
    parameter bit               BYPASS   = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] dataIn,
    output logic [WIDTH-1:0] dataOut,
    output logic [WIDTH-1:0] riseOut,
    output logic [WIDTH-1:0] fallOut
);

    genvar gi;

    generate
        if (BYPASS) begin : g_bypass
            logic bypass_unused;
            assign bypass_unused = &{1'b0, clk, reset};
            assign dataOut = dataIn;
            assign riseOut = '0;
            assign fallOut = '0;
        end else begin : g_sync
            for (gi = 0; gi < WIDTH; gi++) begin : g_ch
                uctl_sync_filter_ch #(
                    .STAGES   (STAGES),
                    .FILT_CNT (FILT_CNT),
                    .RST_BIT  (RST_VAL[gi])
                ) u_ch (
                    .clk     (clk),
                    .reset   (reset),
                    .dataIn  (dataIn[gi]),
                    .dataOut (dataOut[gi]),
                    .riseOut (riseOut[gi]),
                    .fallOut (fallOut[gi])
                );
            end
        end
    endgenerate

endmodule
